ospi_flash_ctrl: RTL
====================

Name: ospi_flash_ctrl

Overview:
Command sequencer upstream of the OSPI flash memory model. Accepts byte-burst READ / PROGRAM / ERASE commands over a valid/ready interface. Expands each command into single-cycle write_enable / read_enable / erase_enable strobes with address and data on the flash's internal-logic port. Captures the flash's registered data_out and returns it on a valid/ready read-data stream.

Parameters:
ADDR_W, 8, flash address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 8, byte width of data_in/data_out.
LEN_W, 8, burst length field width; cmd_len encodes (bytes - 1).

Ports:
clk  in  1  clock, shared with the flash's internal-logic clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, can accept a command
cmd_op  in  2  0=READ, 1=PROGRAM, 2=ERASE, 3=reserved
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  byte count minus one
wdata_valid  in  1  program byte offered
wdata  in  DATA_W  program byte
wdata_ready  out  1  program byte accepted this cycle
rdata_valid  out  1  read byte available
rdata  out  DATA_W  read byte
rdata_ready  in  1  consumer takes read byte
done  out  1  one-cycle pulse at the end of a command
err  out  1  sticky error flag, cleared on next command accept
flash_we  out  1  drives the flash write_enable
flash_re  out  1  drives the flash read_enable
flash_ee  out  1  drives the flash erase_enable
flash_addr  out  ADDR_W  drives the flash address
flash_din  out  DATA_W  drives the flash data_in
flash_dout  in  DATA_W  from the flash data_out

Behaviour:
- Reset (sync, high): state=IDLE; every output 0 except cmd_ready. cmd_ready is combinational from state, so it is 1 after reset.
- Reset during a command: the command is abandoned and flash strobes are 0 from the next cycle. No done pulse is issued.
- All flash_* outputs are registered. At most one of we/re/ee is high in any cycle. flash_addr and flash_din hold their last value when no strobe is active.
- FSM states: IDLE, WR, ER, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch cur_addr=cmd_addr and remaining=cmd_len; clear err.
  - go to RD_ISSUE (op 0), WR (op 1), ER (op 2), or DONE with err=1 (op 3, no flash activity).
- WR: wdata_ready=1.
  - On each wdata_valid handshake: next cycle flash_we=1, flash_addr=cur_addr, flash_din=wdata.
  - cur_addr increments; remaining decrements.
  - The handshake taken with remaining==0 goes to DONE. Back-to-back handshakes give one byte per cycle.
- ER: one flash_ee pulse per cycle at cur_addr, incrementing, for cmd_len+1 consecutive cycles, then DONE.
- RD_ISSUE: flash_re=1 for one cycle at cur_addr.
- RD_WAIT: one cycle; flash_dout is valid here (flash registers on the re edge). Capture into rdata; rdata_valid=1 from the next cycle.
- RD_HOLD: rdata/rdata_valid held stable until rdata_ready. On acceptance: if remaining==0 go to DONE, else decrement, increment cur_addr, go to RD_ISSUE.
  - Read latency: 2 cycles from the re strobe to rdata_valid.
  - Throughput: 1 byte per 3 cycles when rdata_ready is held high.
- DONE: done=1 for exactly one cycle, then IDLE. The next command can be accepted the cycle after DONE.
- Address wrap: 0xFF+1 becomes 0x00 within a burst, with no error.
- cmd_len=0 means a single byte. cmd_len=0xFF means 256 bytes, covering the whole array.
- Inputs on wdata_valid or rdata_ready outside their states are ignored.

Optional Feature:
- Macro OSPI_CTRL_ERASE_VERIFY_EN.
- Defined: after each flash_ee pulse, the FSM inserts EV_ISSUE (flash_re at the same address) and EV_CHECK. In EV_CHECK, if flash_dout != ERASE_VAL (0xFF), set err. The burst continues regardless. Erase cost becomes 3 cycles per byte. No rdata_valid is produced.
- Undefined: these states are absent; erase is 1 cycle per byte and err is only set by reserved opcodes.

Decomposition:
- Package ospi_ctrl_pkg:
  - op encodings OP_READ / OP_PROGRAM / OP_ERASE / OP_RSVD;
  - the FSM state enum;
  - ERASE_VAL = 8'hFF.
- One natural sub-module, ospi_ctrl_addr_gen. It holds cur_addr and remaining with load, step and last outputs, and is reused by all three burst types.

Test Plan:
- Reset, then PROGRAM addr 0x10 len 3 with wdata A0, A1, A2, A3 back-to-back -> flash_we high 4 consecutive cycles at 0x10–0x13; done pulses once; err=0.
- READ addr 0x10 len 3 with rdata_ready=1 -> rdata sequence A0, A1, A2, A3; each arrives 2 cycles after its flash_re; done after the last byte.
- READ addr 0xFE len 2 with rdata_ready low for 5 cycles on byte 2 -> flash_addr goes 0xFE, 0xFF, 0x00; rdata is held stable while stalled; no extra flash_re is issued during the stall.
- ERASE addr 0x11 len 1, then READ addr 0x10 len 3 -> returns A0, FF, FF, A3. With OSPI_CTRL_ERASE_VERIFY_EN, err=0.
- cmd_op=3 -> done one cycle after accept, err=1, no flash strobe. A following valid command clears err.
- Reset asserted mid PROGRAM after 2 of 4 bytes -> all strobes 0 the next cycle, no done, cmd_ready=1. A re-read shows only the first 2 bytes written.

Source files
------------

// File: rtl/ospi_ctrl_pkg.sv
// Shared encodings for the OSPI flash command sequencer.
// The optional post-erase read-back check is enabled by OSPI_CTRL_ERASE_VERIFY_EN.
package ospi_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR,
        ST_ER,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_DONE
`ifdef OSPI_CTRL_ERASE_VERIFY_EN
        , ST_EV_ISSUE
        , ST_EV_CHECK
`endif
    } state_e;

    localparam logic [7:0] ERASE_VAL = 8'hFF;

endpackage

// File: rtl/ospi_ctrl_addr_gen.sv
// Burst address / remaining-count tracker shared by READ, PROGRAM and ERASE bursts.
// Addresses wrap modulo 2^ADDR_W; last is high when the current byte is the final one.
module ospi_ctrl_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              last
);

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;

    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        if (load) begin
            cur_addr_d  = load_addr;
            remaining_d = load_len;
        end else if (step) begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign cur_addr  = cur_addr_q;
    assign next_addr = cur_addr_q + ADDR_W'(1);
    assign last      = (remaining_q == '0);

endmodule

// File: rtl/ospi_flash_ctrl.sv
// OSPI flash command sequencer: expands READ/PROGRAM/ERASE bursts into registered flash strobes.
// Define OSPI_CTRL_ERASE_VERIFY_EN to read back and check every erased byte.
module ospi_flash_ctrl
    import ospi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ready,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    input  logic              rdata_ready,
    output logic              done,
    output logic              err,
    output logic              flash_we,
    output logic              flash_re,
    output logic              flash_ee,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_din,
    input  logic [DATA_W-1:0] flash_dout
);

    state_e            state_q, state_d;
    logic              we_q, we_d, re_q, re_d, ee_q, ee_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ag_load, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr, ag_next;
`ifdef OSPI_CTRL_ERASE_VERIFY_EN
    logic              ev_pend_q, ev_pend_d;
`endif

    ospi_ctrl_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .step      (ag_step),
        .cur_addr  (ag_addr),
        .next_addr (ag_next),
        .last      (ag_last)
    );

    // Read strobes are launched on the transition into RD_ISSUE so the registered
    // re is high during RD_ISSUE and flash_dout is valid in RD_WAIT.
    always_comb begin
        state_d = state_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        ee_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef OSPI_CTRL_ERASE_VERIFY_EN
        // Verify read lands one cycle after EV_CHECK, so the compare is deferred by a flag.
        ev_pend_d = 1'b0;
        if (ev_pend_q && (flash_dout != DATA_W'(ERASE_VAL))) err_d = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ag_load = 1'b1;
                    err_d   = 1'b0;
                    case (op_e'(cmd_op))
                        OP_READ: begin
                            re_d    = 1'b1;
                            addr_d  = cmd_addr;
                            state_d = ST_RD_ISSUE;
                        end
                        OP_PROGRAM: state_d = ST_WR;
                        OP_ERASE:   state_d = ST_ER;
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_WR: begin
                if (wdata_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ag_addr;
                    din_d   = wdata;
                    ag_step = 1'b1;
                    if (ag_last) state_d = ST_DONE;
                end
            end
            ST_ER: begin
                ee_d   = 1'b1;
                addr_d = ag_addr;
`ifdef OSPI_CTRL_ERASE_VERIFY_EN
                state_d = ST_EV_ISSUE;
`else
                ag_step = 1'b1;
                if (ag_last) state_d = ST_DONE;
`endif
            end
`ifdef OSPI_CTRL_ERASE_VERIFY_EN
            ST_EV_ISSUE: begin
                re_d    = 1'b1;
                state_d = ST_EV_CHECK;
            end
            ST_EV_CHECK: begin
                ev_pend_d = 1'b1;
                ag_step   = 1'b1;
                state_d   = ag_last ? ST_DONE : ST_ER;
            end
`endif
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                rdata_d = flash_dout;
                state_d = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                if (rdata_ready) begin
                    if (ag_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ag_step = 1'b1;
                        re_d    = 1'b1;
                        addr_d  = ag_next;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ee_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ee_q    <= ee_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef OSPI_CTRL_ERASE_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) ev_pend_q <= 1'b0;
        else       ev_pend_q <= ev_pend_d;
    end
`endif

    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WR);
    assign rdata_valid = (state_q == ST_RD_HOLD);
    assign rdata       = rdata_q;
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign flash_we    = we_q;
    assign flash_re    = re_q;
    assign flash_ee    = ee_q;
    assign flash_addr  = addr_q;
    assign flash_din   = din_q;

endmodule
